// File: rtl/bicubic_sched_pkg.sv
// bicubic_sched_pkg: shared FSM states, tag type and ID width helper for the round scheduler.
package bicubic_sched_pkg;
  typedef enum logic [1:0] {INIT, RUN, DRAIN} sched_state_t;
  localparam int MAX_ID_W = 3;
  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
  } tag_t;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; SIMD2X_SCHED_PRIO_EN gives requester 0 strict priority.
module rr_arbiter
  import bicubic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
`ifdef SIMD2X_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic [ID_W-1:0] last;
  logic            hit;
  int              j;
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    j      = 0;
    hit    = PRIO && req[0];
    gnt[0] = hit;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!hit && req[j[ID_W-1:0]] && !(PRIO && j == 0)) begin
        gnt[j[ID_W-1:0]] = 1'b1;
        gnt_id           = j[ID_W-1:0];
        hit              = 1'b1;
      end
    end
  end
  // priority grants to requester 0 leave the rotation of the others untouched
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) last <= ID_W'(NUM_REQ - 1);
    else if (|gnt && !(PRIO && gnt[0])) last <= gnt_id;
endmodule

// File: rtl/simd2x_round_sched.sv
// simd2x_round_sched: shares one simd2x_round unit among NUM_REQ requesters with tag tracking.
// Option: SIMD2X_SCHED_PRIO_EN makes requester 0 strict-priority (see rr_arbiter).
module simd2x_round_sched
  import bicubic_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 48,
  parameter int OUTPUT_WIDTH   = 9,
  parameter int ROUND_LATENCY  = 2,
  parameter int DSP_RST_CYCLES = 4,
  parameter int ID_W           = id_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_ch0,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_ch1,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           round_clken,
  output logic                           round_dsp_reset,
  output logic [INPUT_WIDTH-1:0]         round_rin_ch0,
  output logic [INPUT_WIDTH-1:0]         round_rin_ch1,
  input  logic [OUTPUT_WIDTH-1:0]        round_rout_ch0,
  input  logic [OUTPUT_WIDTH-1:0]        round_rout_ch1,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [OUTPUT_WIDTH-1:0]        out_ch0,
  output logic [OUTPUT_WIDTH-1:0]        out_ch1,
  output logic                           busy
);
  localparam int CW = $clog2(DSP_RST_CYCLES + 1);
  sched_state_t           st, nxt;
  logic [CW-1:0]          cnt;
  logic                   adv, grant_en, iss_v, tag_busy;
  logic [ID_W-1:0]        iss_id, gnt_id;
  logic [NUM_REQ-1:0]     gnt;
  logic [INPUT_WIDTH-1:0] sel_ch0, sel_ch1;
  tag_t                   tag [ROUND_LATENCY];
  // the whole pipe (issue reg, unit, tags, output reg) moves as one when the output can accept
  assign adv             = st != INIT && (!out_valid || out_ready);
  assign grant_en        = st == RUN && !flush_req && adv;
  assign round_clken     = st == INIT || adv;
  assign round_dsp_reset = st == INIT;
  assign req_ready       = gnt;
  assign busy            = iss_v || tag_busy || out_valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk    (clk),
    .aresetn(aresetn),
    .req    (grant_en ? req_valid : '0),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  always_comb begin
    sel_ch0  = '0;
    sel_ch1  = '0;
    tag_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_ch0 = req_ch0[i*INPUT_WIDTH +: INPUT_WIDTH];
        sel_ch1 = req_ch1[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    for (int i = 0; i < ROUND_LATENCY; i++) tag_busy = tag_busy | tag[i].v;
  end
  always_comb begin
    nxt        = st;
    flush_done = 1'b0;
    if (st == INIT) nxt = (cnt == CW'(DSP_RST_CYCLES - 1)) ? RUN : INIT;
    else if (st == RUN) nxt = flush_req ? DRAIN : RUN;
    else if (!busy) begin
      nxt        = RUN;
      flush_done = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      st  <= INIT;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= (st == INIT) ? cnt + 1'b1 : '0;
    end
  // last tag stage lines up with round_rout_* so the output reg captures id and data together
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      iss_v         <= 1'b0;
      iss_id        <= '0;
      round_rin_ch0 <= '0;
      round_rin_ch1 <= '0;
      for (int i = 0; i < ROUND_LATENCY; i++) tag[i] <= '0;
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_ch0       <= '0;
      out_ch1       <= '0;
    end else if (adv) begin
      iss_v         <= |gnt;
      iss_id        <= gnt_id;
      round_rin_ch0 <= sel_ch0;
      round_rin_ch1 <= sel_ch1;
      tag[0]        <= '{v: iss_v, id: MAX_ID_W'(iss_id)};
      for (int i = 1; i < ROUND_LATENCY; i++) tag[i] <= tag[i-1];
      out_valid     <= tag[ROUND_LATENCY-1].v;
      out_id        <= tag[ROUND_LATENCY-1].id[ID_W-1:0];
      out_ch0       <= round_rout_ch0;
      out_ch1       <= round_rout_ch1;
    end
endmodule

// File: tb/tb_simd2x_round_sched.sv
// tb_simd2x_round_sched: directed/random bench with a round-unit model and an in-order scoreboard.
module tb_simd2x_round_sched;
  localparam int N = 4, IW = 48, OW = 9, L = 2, ID_W = 2, EW = ID_W + 2*OW;
`ifdef SIMD2X_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 0, aresetn, flush_req, flush_done, round_clken, round_dsp_reset;
  logic out_valid, out_ready, busy;
  logic [N-1:0] req_valid, req_ready;
  logic [N*IW-1:0] req_ch0, req_ch1;
  logic [IW-1:0] round_rin_ch0, round_rin_ch1;
  logic [OW-1:0] round_rout_ch0, round_rout_ch1, out_ch0, out_ch1;
  logic [ID_W-1:0] out_id;
  logic [OW-1:0] p0 [L], p1 [L];
  logic [EW-1:0] sbq [$];
  logic [EW:0] held;
  logic was_stall = 0;
  int errs = 0, checks = 0, exp_last = N - 1, n_hs = 0, n_out = 0, n_stall = 0;
  int mark, pulses;
  always #5 clk = ~clk;
  simd2x_round_sched dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch0(req_ch0), .req_ch1(req_ch1), .flush_req(flush_req), .flush_done(flush_done),
    .round_clken(round_clken), .round_dsp_reset(round_dsp_reset),
    .round_rin_ch0(round_rin_ch0), .round_rin_ch1(round_rin_ch1),
    .round_rout_ch0(round_rout_ch0), .round_rout_ch1(round_rout_ch1),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_ch0(out_ch0), .out_ch1(out_ch1), .busy(busy)
  );
  // 2-lane round unit: round half up, drop 8 fraction bits, L clken edges of latency
  function automatic logic [OW-1:0] rnd(input logic [IW-1:0] x);
    logic [IW:0] t;
    t = {1'b0, x} + (IW+1)'(128);
    return t[OW+7:8];
  endfunction
  always @(posedge clk)
    if (round_dsp_reset) begin
      for (int s = 0; s < L; s++) begin
        p0[s] <= '0;
        p1[s] <= '0;
      end
    end else if (round_clken) begin
      p0[0] <= rnd(round_rin_ch0);
      p1[0] <= rnd(round_rin_ch1);
      for (int s = 1; s < L; s++) begin
        p0[s] <= p0[s-1];
        p1[s] <= p1[s-1];
      end
    end
  assign round_rout_ch0 = p0[L-1];
  assign round_rout_ch1 = p1[L-1];
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v);
    int j;
    if (PRIO && v[0]) return N'(1);
    for (int k = 1; k <= N; k++) begin
      j = (exp_last + k) % N;
      if (v[j[ID_W-1:0]] && !(PRIO && j == 0)) return N'(1) << j;
    end
    return '0;
  endfunction
  task automatic drive(input logic [N-1:0] v);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_ch0[i*IW +: IW] = IW'({$urandom, $urandom});
      req_ch1[i*IW +: IW] = IW'({$urandom, $urandom});
    end
  endtask
  task automatic obs;
    @(negedge clk);
    if (|req_ready) chk("grant", req_ready, exp_grant(req_valid));
    if (out_valid && !out_ready) begin
      n_stall++;
      chk("stall_clken", round_clken, 0);
      chk("stall_nogrant", req_ready, 0);
    end
    if (was_stall) chk("stall_hold", {out_valid, out_id, out_ch0, out_ch1}, held);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        sbq.push_back({ID_W'(i), rnd(req_ch0[i*IW +: IW]), rnd(req_ch1[i*IW +: IW])});
        n_hs++;
        if (!(PRIO && i == 0)) exp_last = i;
      end
    if (out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) chk("spurious", out_valid, 0);
      else chk("result", {out_id, out_ch0, out_ch1}, sbq.pop_front());
    end
    was_stall = out_valid && !out_ready;
    held      = {out_valid, out_id, out_ch0, out_ch1};
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step;
    obs;
    tick;
  endtask
  task automatic rst_checks;
    chk("rst_dsp_reset", round_dsp_reset, 1);
    chk("rst_clken", round_clken, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_out", {out_valid, out_id, out_ch0, out_ch1}, 0);
    chk("rst_rin0", round_rin_ch0, 0);
    chk("rst_rin1", round_rin_ch1, 0);
    chk("rst_busy_flush", {busy, flush_done}, 0);
  endtask
  initial begin
    aresetn = 0;
    flush_req = 0;
    out_ready = 1;
    drive(4'b0100);
    req_ch0[2*IW +: IW] = 48'h000000000180;
    req_ch1[2*IW +: IW] = 48'h00000000017F;
    repeat (2) begin
      obs;
      rst_checks;
      tick;
    end
    aresetn = 1;
    for (int c = 1; c <= 4; c++) begin
      obs;
      chk("init_dsp_reset", round_dsp_reset, 1);
      chk("init_ready", req_ready, 0);
      tick;
    end
    obs;
    chk("run_dsp_reset", round_dsp_reset, 0);
    chk("first_accept", req_ready, 4'b0100);
    tick;
    drive(0);
    for (int c = 1; c <= 3; c++) begin
      obs;
      chk("lat_early", out_valid, 0);
      tick;
    end
    obs;
    chk("lat_valid", out_valid, 1);
    chk("single_id", out_id, 2);
    chk("single_ch0", out_ch0, 2);
    chk("single_ch1", out_ch1, 1);
    tick;
    mark = n_hs;
    repeat (20) begin
      drive('1);
      step;
    end
    chk("throughput", n_hs - mark, 20);
    drive(0);
    repeat (8) step;
    chk("drain_all", sbq.size(), 0);
    repeat (6) begin
      drive('1);
      step;
    end
    out_ready = 0;
    mark = n_stall;
    repeat (5) begin
      drive('1);
      step;
    end
    chk("stall_seen", n_stall - mark, 5);
    out_ready = 1;
    repeat (10) begin
      drive(N'($urandom));
      step;
    end
    drive(0);
    repeat (8) step;
    chk("drain_bp", sbq.size(), 0);
    mark = n_hs;
    drive('1);
    repeat (3) step;
    chk("flush_inflight", n_hs - mark, 3);
    flush_req = 1;
    pulses = 0;
    repeat (20) begin
      obs;
      if (flush_req) chk("flush_nogrant", req_ready, 0);
      if (flush_done) begin
        pulses++;
        chk("flush_busy", busy, 0);
        chk("flush_sb", sbq.size(), 0);
      end
      tick;
      if (pulses > 0 && flush_req) begin
        flush_req = 0;
        drive(0);
      end
    end
    chk("flush_once", pulses, 1);
    drive('1);
    repeat (2) step;
    drive(0);
    step;
    aresetn = 0;
    obs;
    rst_checks;
    sbq.delete();
    exp_last = N - 1;
    was_stall = 0;
    tick;
    aresetn = 1;
    mark = n_out;
    repeat (16) step;
    chk("no_stale", n_out - mark, 0);
    repeat (40) begin
      drive(N'($urandom));
      out_ready = 1'($urandom);
      step;
    end
    out_ready = 1;
    drive(0);
    repeat (10) step;
    chk("final_drain", sbq.size(), 0);
    chk("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
